// File: rtl/mem_access_arbiter.sv
// Single-port memory sequencer for the multicycle CPU: fetch/data arbitration,
// kernel-region protection and two memory-mapped I/O words. Optional macro: ROUND_ROBIN_EN.
module mem_access_arbiter #(
    parameter int                 ADDR_W       = 16,
    parameter int                 DATA_W       = 16,
    parameter logic [ADDR_W-1:0]  KERNEL_LIMIT = 16'h1000,
    parameter logic [ADDR_W-1:0]  IO_IN_ADDR   = 16'hFFF0,
    parameter logic [ADDR_W-1:0]  IO_OUT_ADDR  = 16'hFFF1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              kernel_flag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] io_input,
    input  logic              io_input_valid,
    output logic              io_input_ack,
    output logic [DATA_W-1:0] display_out,
    output logic              acc_inv,
    output logic              busy
);
    // Handshake: a requester holds req until its one-cycle gnt; address/data are
    // sampled only at the arbitration edge, and a read returns data on the next cycle's rvalid.
    typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
    typedef enum logic [1:0] {RD_RAM, RD_ZERO, RD_LATCH} rsel_t;

    state_t              state_q, state_d;
    rsel_t               rsel_q, rsel_d;
    logic                win_data_q, win_data_d;
    logic                store_q, store_d;
    logic                last_data_q, last_data_d;
    logic                disp_wr_q, disp_wr_d;
    logic                if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic                if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d;
    logic                mem_we_q, mem_we_d, acc_inv_q, acc_inv_d, ack_q, ack_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, disp_q, disp_d, latch_q, latch_d;

    logic                pick_data, prio_data, viol, is_io_in, is_io_out;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   rdata_mux;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rsel_q      <= RD_ZERO;
            win_data_q  <= 1'b0;
            store_q     <= 1'b0;
            last_data_q <= 1'b0;
            disp_wr_q   <= 1'b0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            acc_inv_q   <= 1'b0;
            ack_q       <= 1'b0;
            mem_addr_q  <= '0;
            wdata_q     <= '0;
            disp_q      <= '0;
            latch_q     <= '0;
        end else begin
            state_q     <= state_d;
            rsel_q      <= rsel_d;
            win_data_q  <= win_data_d;
            store_q     <= store_d;
            last_data_q <= last_data_d;
            disp_wr_q   <= disp_wr_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            mem_we_q    <= mem_we_d;
            acc_inv_q   <= acc_inv_d;
            ack_q       <= ack_d;
            mem_addr_q  <= mem_addr_d;
            wdata_q     <= wdata_d;
            disp_q      <= disp_d;
            latch_q     <= latch_d;
        end
    end

`ifdef ROUND_ROBIN_EN
    assign prio_data = ~last_data_q;
`else
    assign prio_data = 1'b1;
`endif

    assign pick_data = d_req & (~if_req | prio_data);
    assign sel_addr  = pick_data ? d_addr : if_addr;
    assign is_io_in  = (sel_addr == IO_IN_ADDR);
    assign is_io_out = (sel_addr == IO_OUT_ADDR);
    assign viol      = (sel_addr < KERNEL_LIMIT) & ~kernel_flag;

    always_comb begin
        state_d     = state_q;
        rsel_d      = rsel_q;
        win_data_d  = win_data_q;
        store_d     = store_q;
        last_data_d = last_data_q;
        wdata_d     = wdata_q;
        disp_d      = disp_q;
        latch_d     = io_input_valid ? io_input : latch_q;
        disp_wr_d   = 1'b0;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        mem_we_d    = 1'b0;
        acc_inv_d   = 1'b0;
        ack_d       = 1'b0;
        mem_addr_d  = '0;
        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    state_d     = ST_ACCESS;
                    win_data_d  = pick_data;
                    last_data_d = pick_data;
                    store_d     = pick_data & d_we;
                    d_gnt_d     = pick_data;
                    if_gnt_d    = ~pick_data;
                    mem_addr_d  = sel_addr;
                    wdata_d     = d_wdata;
                    rsel_d      = RD_RAM;
                    if (!pick_data) begin
                        // Instruction fetch from I/O space is always illegal.
                        if (is_io_in || is_io_out || viol) begin
                            acc_inv_d = 1'b1;
                            rsel_d    = RD_ZERO;
                        end
                    end else if (d_we) begin
                        if (is_io_out)     disp_wr_d = 1'b1;
                        else if (is_io_in) disp_wr_d = 1'b0;
                        else if (viol)     acc_inv_d = 1'b1;
                        else               mem_we_d  = 1'b1;
                    end else begin
                        if (is_io_in) begin
                            ack_d  = 1'b1;
                            rsel_d = RD_LATCH;
                        end else if (is_io_out) begin
                            rsel_d = RD_ZERO;
                        end else if (viol) begin
                            acc_inv_d = 1'b1;
                            rsel_d    = RD_ZERO;
                        end
                    end
                end
            end
            ST_ACCESS: begin
                if (disp_wr_q) disp_d = wdata_q;
                if (store_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                    if_rvalid_d = ~win_data_q;
                    d_rvalid_d  = win_data_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        case (rsel_q)
            RD_RAM:   rdata_mux = mem_rdata;
            RD_LATCH: rdata_mux = latch_q;
            default:  rdata_mux = '0;
        endcase
    end

    assign if_gnt       = if_gnt_q;
    assign d_gnt        = d_gnt_q;
    assign if_rvalid    = if_rvalid_q;
    assign d_rvalid     = d_rvalid_q;
    assign if_rdata     = if_rvalid_q ? rdata_mux : '0;
    assign d_rdata      = d_rvalid_q ? rdata_mux : '0;
    assign mem_addr     = mem_addr_q;
    assign mem_we       = mem_we_q;
    assign mem_wdata    = mem_we_q ? wdata_q : '0;
    assign io_input_ack = ack_q;
    assign display_out  = disp_q;
    assign acc_inv      = acc_inv_q;
    assign busy         = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a one-cycle-latency RAM model.
module tb_mem_access_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, kernel_flag = 1'b0;
  logic [15:0] if_addr = '0, d_addr = '0, d_wdata = '0, io_input = '0;
  logic        io_input_valid = 1'b0;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_we, io_input_ack, acc_inv, busy;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata, display_out;

  logic [15:0] ram [0:65535];
  logic        bd_we = 1'b0;
  logic [15:0] bd_addr = '0, bd_data = '0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  mem_access_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .kernel_flag(kernel_flag),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .io_input(io_input), .io_input_valid(io_input_valid), .io_input_ack(io_input_ack),
    .display_out(display_out), .acc_inv(acc_inv), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    bd_we = 1'b1; bd_addr = a; bd_data = v;
    step();
    bd_we = 1'b0;
  endtask

  initial begin
    // clock/reset and RAM preload
    preload(16'h3000, 16'h0CDE);
    preload(16'h3001, 16'hB7D2);
    preload(16'h0800, 16'h5555);
    preload(16'h1000, 16'hABCD);
    chk("rst_busy", {15'd0, busy}, 16'h0000);
    chk("rst_gnt", {14'd0, if_gnt, d_gnt}, 16'h0000);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_display", display_out, 16'h0000);
    rst = 1'b0;
    step();
    chk("idle_mem_we", {15'd0, mem_we}, 16'h0000);

    // fetch read, kernel mode
    kernel_flag = 1'b1;
    if_req = 1'b1; if_addr = 16'h3000;
    step(); if_req = 1'b0;
    chk("f_gnt", {15'd0, if_gnt}, 16'h0001);
    chk("f_busy1", {15'd0, busy}, 16'h0001);
    chk("f_mem_addr", mem_addr, 16'h3000);
    chk("f_rvalid_early", {15'd0, if_rvalid}, 16'h0000);
    step();
    chk("f_rvalid", {15'd0, if_rvalid}, 16'h0001);
    chk("f_rdata", if_rdata, 16'h0CDE);
    chk("f_busy2", {15'd0, busy}, 16'h0001);
    step();
    chk("f_idle", {15'd0, busy}, 16'h0000);

    // simultaneous requests: data wins, fetch served on the next arbitration
    if_req = 1'b1; if_addr = 16'h3000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h3001;
    step(); d_req = 1'b0;
    chk("tie_d_gnt", {14'd0, d_gnt, if_gnt}, 16'h0002);
    step();
    chk("tie_d_rvalid", {15'd0, d_rvalid}, 16'h0001);
    chk("tie_d_rdata", d_rdata, 16'hB7D2);
    step();
    chk("tie_if_wait", {15'd0, if_gnt}, 16'h0000);
    step(); if_req = 1'b0;
    chk("tie_if_gnt", {15'd0, if_gnt}, 16'h0001);
    step();
    chk("tie_if_rdata", if_rdata, 16'h0CDE);
    step();

    // protected store in user mode; kernel_flag flip during ACCESS is ignored
    kernel_flag = 1'b0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0800; d_wdata = 16'hDC14;
    step(); d_req = 1'b0; kernel_flag = 1'b1;
    chk("viol_gnt", {15'd0, d_gnt}, 16'h0001);
    chk("viol_acc_inv", {15'd0, acc_inv}, 16'h0001);
    chk("viol_mem_we", {15'd0, mem_we}, 16'h0000);
    step();
    chk("viol_done", {14'd0, busy, mem_we}, 16'h0000);
    chk("viol_ram", ram[16'h0800], 16'h5555);

    // same store in kernel mode, then read back
    d_req = 1'b1;
    step(); d_req = 1'b0;
    chk("ks_mem_we", {15'd0, mem_we}, 16'h0001);
    chk("ks_wdata", mem_wdata, 16'hDC14);
    chk("ks_acc_inv", {15'd0, acc_inv}, 16'h0000);
    step();
    chk("ks_idle", {15'd0, busy}, 16'h0000);
    d_req = 1'b1; d_we = 1'b0;
    step(); d_req = 1'b0;
    step();
    chk("ks_readback", d_rdata, 16'hDC14);
    step();

    // user-mode fetch below the limit returns zero; exactly at the limit is legal
    kernel_flag = 1'b0;
    if_req = 1'b1; if_addr = 16'h0800;
    step(); if_req = 1'b0;
    chk("uf_acc_inv", {15'd0, acc_inv}, 16'h0001);
    step();
    chk("uf_rvalid", {15'd0, if_rvalid}, 16'h0001);
    chk("uf_rdata", if_rdata, 16'h0000);
    step();
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h1000;
    step(); d_req = 1'b0;
    chk("lim_acc_inv", {15'd0, acc_inv}, 16'h0000);
    step();
    chk("lim_rdata", d_rdata, 16'hABCD);
    step();
    kernel_flag = 1'b1;

    // I/O input port
    io_input = 16'hDCEC; io_input_valid = 1'b1;
    step(); io_input_valid = 1'b0; io_input = 16'h0000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'hFFF0;
    step(); d_req = 1'b0;
    chk("io_ack", {15'd0, io_input_ack}, 16'h0001);
    chk("io_mem_we", {15'd0, mem_we}, 16'h0000);
    step();
    chk("io_rdata", d_rdata, 16'hDCEC);
    chk("io_ack_off", {15'd0, io_input_ack}, 16'h0000);
    step();

    // display register
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'hFFF1; d_wdata = 16'h1234;
    step(); d_req = 1'b0;
    chk("disp_mem_we", {15'd0, mem_we}, 16'h0000);
    chk("disp_before", display_out, 16'h0000);
    step();
    chk("disp_k2", display_out, 16'h1234);
    step();
    chk("disp_hold", display_out, 16'h1234);

    // fetch from I/O space
    if_req = 1'b1; if_addr = 16'hFFF0;
    step(); if_req = 1'b0;
    chk("iof_acc_inv", {15'd0, acc_inv}, 16'h0001);
    step();
    chk("iof_rdata", if_rdata, 16'h0000);
    step();

    // reset during ACCESS of a read
    if_req = 1'b1; if_addr = 16'h3000;
    step(); if_req = 1'b0;
    chk("rr_gnt", {15'd0, if_gnt}, 16'h0001);
    #2 rst = 1'b1;
    #1;
    chk("rr_async", {13'd0, if_gnt, busy, mem_we}, 16'h0000);
    chk("rr_mem_addr", mem_addr, 16'h0000);
    chk("rr_display", display_out, 16'h0000);
    step(); rst = 1'b0;
    step();
    chk("rr_no_rvalid1", {15'd0, if_rvalid}, 16'h0000);
    step();
    chk("rr_no_rvalid2", {15'd0, if_rvalid}, 16'h0000);
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h3001;
    step(); d_req = 1'b0;
    chk("rr_next_gnt", {15'd0, d_gnt}, 16'h0001);
    step();
    chk("rr_next_rdata", d_rdata, 16'hB7D2);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_arbiter.md
Name: mem_access_arbiter

Overview:
- Sequences the single-port 16-bit main memory for the multicycle CPU.
- Shares memory between two requesters: instruction fetch (PC side) and data load/store (ALUOut/WriteData side).
- Enforces kernel-region protection and flags violations on acc_inv.
- Decodes two memory-mapped I/O words: a latched input port and the display output register.

Parameters:
- ADDR_W, 16, address width.
- DATA_W, 16, data width.
- KERNEL_LIMIT, 16'h1000, addresses below this value are kernel-only.
- IO_IN_ADDR, 16'hFFF0, read address of the input port.
- IO_OUT_ADDR, 16'hFFF1, write address of the display register.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address (PC).
- if_gnt  out  1  fetch grant, 1-cycle pulse.
- if_rvalid  out  1  fetch data valid, 1-cycle pulse.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data grant pulse.
- d_rvalid  out  1  load data valid pulse.
- d_rdata  out  DATA_W  load data.
- kernel_flag  in  1  CPU is in kernel mode.
- mem_addr  out  ADDR_W  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid one cycle after the address is presented.
- io_input  in  DATA_W  external input word.
- io_input_valid  in  1  io_input holds new data.
- io_input_ack  out  1  input consumed pulse (InputRecv).
- display_out  out  DATA_W  display register.
- acc_inv  out  1  access-violation pulse.
- busy  out  1  arbiter not in IDLE.

Behaviour:
- Reset (asynchronous, any state): state IDLE. All outputs 0, including display_out and the input latch. Any pending read is dropped; no rvalid follows reset.
- Input latch: on io_input_valid=1, io_input is captured into the latch.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any request is present at edge k, select a winner, go to ACCESS, and register the grant and memory controls. With no request, stay in IDLE with mem_we=0.
- ACCESS (cycle k+1):
  - Winner's gnt=1; mem_addr = winner address.
  - Store: mem_we=1, mem_wdata=d_wdata, then go to IDLE.
  - Load or fetch: go to RESP.
- RESP (cycle k+2): winner's rvalid=1 and rdata=mem_rdata, then go to IDLE.
- Latency: read grant at k+1, data at k+2. Store grant at k+1. Arbitration happens only in IDLE, so the next grant is no earlier than k+3 after a read and k+2 after a store.
- Arbitration default: fixed priority, data over fetch.
- Protection: if the address is < KERNEL_LIMIT and kernel_flag=0, the access is a violation:
  - gnt still issues.
  - acc_inv=1 in ACCESS.
  - mem_we stays 0.
  - A read still completes in RESP with rdata=0.
- I/O access bypasses protection and RAM (mem_we=0):
  - Load from IO_IN_ADDR: returns the input latch in RESP; io_input_ack pulses in ACCESS.
  - Store to IO_OUT_ADDR: display_out <= d_wdata at the end of ACCESS.
  - Fetch from either I/O address returns 0 and raises acc_inv.
- Requests dropped before their grant are ignored. Address and data are sampled only at edge k.
- kernel_flag is sampled at edge k; a change during ACCESS does not affect the in-flight access.
- Address wrap: none. Addresses are used as-is, full 16-bit range.

Optional Feature:
- Macro ROUND_ROBIN_EN.
- Defined: when both requesters are active in IDLE, the one not granted last wins. The last-granted record resets to fetch, so data wins the first tie. A lone requester always wins.
- Undefined: fixed data-over-fetch priority; continuous data requests can starve fetch.

Test Plan:
- Fetch read, kernel_flag=1: RAM[16'h3000]=16'h0CDE, if_req at edge k -> if_gnt at k+1, if_rvalid with if_rdata=16'h0CDE at k+2, busy high over k+1..k+2.
- Simultaneous if_req and d_req (load 16'h3001, RAM=16'hB7D2):
  - Macro undefined: d_gnt at k+1, d_rdata=16'hB7D2 at k+2, if_gnt at k+4 (next IDLE arbitration at edge k+3).
  - ROUND_ROBIN_EN defined, repeated ties: grants alternate data, fetch, data.
- Store 16'hDC14 to 16'h0800 with kernel_flag=0 -> acc_inv=1 at k+1, mem_we never 1, RAM unchanged. Same store with kernel_flag=1 -> mem_we=1 at k+1, and a later read returns 16'hDC14.
- I/O:
  - io_input=16'hDCEC with io_input_valid pulse, then load IO_IN_ADDR -> io_input_ack at k+1, d_rdata=16'hDCEC at k+2.
  - Store 16'h1234 to IO_OUT_ADDR -> display_out=16'h1234 from k+2 onward.
- Reset asserted during ACCESS of a read -> all outputs 0 immediately, no rvalid after release, next request served normally.
